ascon_out_packer: RTL and testbench

//  Downstream stage of the SoC encryption wrapper. It waits for encryption_readyxSI,

---
 rtl/ascon_pkg.sv | 16 +
 rtl/ascon_out_packer_if.sv | 26 ++
 rtl/ascon_word_fifo.sv | 74 +++++++
 rtl/ascon_out_packer.sv | 115 +++++++++++
 tb/tb_ascon_out_packer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ascon_pkg.sv
// Shared constants and packer state encoding for the ASCON output path.
package ascon_pkg;

  localparam int unsigned TAG_BYTES  = 16;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    REQ,
    COLLECT,
    FLUSH,
    DONE
  } pk_state_e;

endpackage

// File: rtl/ascon_out_packer_if.sv
// Core-side byte stream and CPU-side word pop port of the output packer.
interface ascon_out_packer_if;

  logic        startxSI;
  logic        encryption_readyxSI;
  logic        reg_outxSO;
  logic [7:0]  cipher_tagxSI;
  logic        output_readyxSI;
  logic [31:0] wordxSO;
  logic        word_validxSO;
  logic        word_readxSI;
  logic [7:0]  byte_countxSO;
  logic        donexSO;
  logic        overflowxSO;

  modport master (
    output startxSI, encryption_readyxSI, cipher_tagxSI, output_readyxSI, word_readxSI,
    input  reg_outxSO, wordxSO, word_validxSO, byte_countxSO, donexSO, overflowxSO
  );

  modport slave (
    input  startxSI, encryption_readyxSI, cipher_tagxSI, output_readyxSI, word_readxSI,
    output reg_outxSO, wordxSO, word_validxSO, byte_countxSO, donexSO, overflowxSO
  );

endinterface

// File: rtl/ascon_word_fifo.sv
// 32-bit word FIFO with a registered head word; pop is applied before push.
module ascon_word_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] wdata,
  input  logic        pop,
  output logic [31:0] head,
  output logic        empty,
  output logic        full,
  output logic        dropped
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] FullCnt = Depth[AW:0];

  logic [31:0]   mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   head_q, head_d;
  logic          pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCnt);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push_ok = push && (!full || pop_ok);
  assign dropped = push && !push_ok;
  assign head    = head_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Head tracks the entry at the post-update read pointer, bypassing a same-cycle write.
  always_comb begin
    head_d = '0;
    if (count_d != '0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) head_d = wdata;
      else                                    head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/ascon_out_packer.sv
// Captures the core's ciphertext||tag byte stream, packs it MSB-first into words and queues them.
module ascon_out_packer
  import ascon_pkg::*;
#(
  parameter int unsigned Y          = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  ascon_out_packer_if.slave bus
);

  localparam int unsigned NBytes  = Y / 8 + TAG_BYTES;
  localparam logic [7:0]  NCnt    = 8'(NBytes);
  localparam logic        Partial = (NBytes % WORD_BYTES) != 0;

  pk_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] lanes_q, lanes_d, lanes_nxt;
  logic        ovf_q, ovf_d;
  logic        arm_clear;
  logic        push;
  logic [31:0] push_word;
  logic        dropped;
  logic        fifo_empty;
  logic        fifo_full;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lanes_d   = lanes_q;
    lanes_nxt = lanes_q;
    arm_clear = 1'b0;
    push      = 1'b0;
    push_word = lanes_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.startxSI) begin
          state_d   = ARMED;
          cnt_d     = '0;
          lanes_d   = '0;
          arm_clear = 1'b1;
        end
      end
      ARMED: begin
        if (bus.encryption_readyxSI) state_d = REQ;
      end
      REQ: state_d = COLLECT;
      COLLECT: begin
        if (bus.output_readyxSI) begin
          unique case (cnt_q[1:0])
            2'd0: lanes_nxt[31:24] = bus.cipher_tagxSI;
            2'd1: lanes_nxt[23:16] = bus.cipher_tagxSI;
            2'd2: lanes_nxt[15:8]  = bus.cipher_tagxSI;
            2'd3: lanes_nxt[7:0]   = bus.cipher_tagxSI;
            default: lanes_nxt = lanes_q;
          endcase
          cnt_d = cnt_q + 8'd1;
          if (cnt_q[1:0] == 2'd3) begin
            push      = 1'b1;
            push_word = lanes_nxt;
            lanes_d   = '0;
          end else begin
            lanes_d = lanes_nxt;
          end
          if (cnt_d == NCnt) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Unfilled low lanes are already zero.
        push    = Partial;
        lanes_d = '0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ovf_d = arm_clear ? 1'b0 : (ovf_q | dropped);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lanes_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
      ovf_q   <= ovf_d;
    end
  end

  ascon_word_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wdata   (push_word),
    .pop     (bus.word_readxSI),
    .head    (bus.wordxSO),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .dropped (dropped)
  );

  assign bus.word_validxSO = !fifo_empty;
  assign bus.reg_outxSO    = (state_q == REQ);
  assign bus.donexSO       = (state_q == DONE);
  assign bus.byte_countxSO = cnt_q;
  assign bus.overflowxSO   = ovf_q;

endmodule

// File: tb/tb_ascon_out_packer.sv
// Two packer configurations (Y=64/depth 4, Y=40/depth 8) driven by one stimulus stream.
module tb_ascon_out_packer;

  localparam int NI        = 2;
  localparam int PhIdle    = 0;
  localparam int PhArmed   = 1;
  localparam int PhReq     = 2;
  localparam int PhCollect = 3;
  localparam int PhFlush   = 4;
  localparam int PhDone    = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start, ready, strobe, rd;
  logic [7:0] byt;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  ascon_out_packer_if b64 ();
  ascon_out_packer_if b40 ();

  assign b64.startxSI            = start;
  assign b64.encryption_readyxSI = ready;
  assign b64.cipher_tagxSI       = byt;
  assign b64.output_readyxSI     = strobe;
  assign b64.word_readxSI        = rd;
  assign b40.startxSI            = start;
  assign b40.encryption_readyxSI = ready;
  assign b40.cipher_tagxSI       = byt;
  assign b40.output_readyxSI     = strobe;
  assign b40.word_readxSI        = rd;

  ascon_out_packer #(.Y(64), .FIFO_DEPTH(4)) u_dut64 (.clk(clk), .rst(rst), .bus(b64.slave));
  ascon_out_packer #(.Y(40), .FIFO_DEPTH(8)) u_dut40 (.clk(clk), .rst(rst), .bus(b40.slave));

  // Reference model: run bytes kept as a list, FIFO as a queue of words.
  int          n_of[NI]     = '{24, 21};
  int          depth_of[NI] = '{4, 8};
  int          phase[NI];
  int          cnt[NI];
  bit          ovf[NI];
  logic [7:0]  mbytes[NI][$];
  logic [31:0] mq[NI][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(int i, int k);
    logic [31:0] w = '0;
    for (int j = 0; j < 4; j++) begin
      int idx = 4 * k + j;
      w = {w[23:0], (idx < mbytes[i].size()) ? mbytes[i][idx] : 8'h00};
    end
    return w;
  endfunction

  task automatic mpush(int i, logic [31:0] w);
    if (mq[i].size() < depth_of[i]) mq[i].push_back(w);
    else ovf[i] = 1'b1;
  endtask

  task automatic mreset(int i);
    phase[i] = PhIdle;
    cnt[i]   = 0;
    ovf[i]   = 1'b0;
    mbytes[i].delete();
    mq[i].delete();
  endtask

  task automatic mstep(int i);
    if (rd && mq[i].size() > 0) void'(mq[i].pop_front());
    case (phase[i])
      PhIdle, PhDone: begin
        if (start) begin
          phase[i] = PhArmed;
          cnt[i]   = 0;
          ovf[i]   = 1'b0;
          mbytes[i].delete();
        end
      end
      PhArmed: if (ready) phase[i] = PhReq;
      PhReq:   phase[i] = PhCollect;
      PhCollect: begin
        if (strobe) begin
          mbytes[i].push_back(byt);
          cnt[i]++;
          if (cnt[i] % 4 == 0) mpush(i, word_of(i, cnt[i] / 4 - 1));
          if (cnt[i] == n_of[i]) phase[i] = PhFlush;
        end
      end
      PhFlush: begin
        if (n_of[i] % 4 != 0) mpush(i, word_of(i, n_of[i] / 4));
        phase[i] = PhDone;
      end
      default: phase[i] = PhIdle;
    endcase
  endtask

  task automatic compare(int i);
    logic [31:0] aw;
    logic        av, ar, ad, ao;
    logic [7:0]  ac;
    string       p;
    if (i == 0) begin
      aw = b64.wordxSO; av = b64.word_validxSO; ar = b64.reg_outxSO;
      ad = b64.donexSO; ao = b64.overflowxSO; ac = b64.byte_countxSO; p = "y64";
    end else begin
      aw = b40.wordxSO; av = b40.word_validxSO; ar = b40.reg_outxSO;
      ad = b40.donexSO; ao = b40.overflowxSO; ac = b40.byte_countxSO; p = "y40";
    end
    chk({p, ".word"}, aw, (mq[i].size() > 0) ? mq[i][0] : 32'h0);
    chk({p, ".word_valid"}, {31'h0, av}, {31'h0, mq[i].size() > 0});
    chk({p, ".reg_out"}, {31'h0, ar}, {31'h0, phase[i] == PhReq});
    chk({p, ".done"}, {31'h0, ad}, {31'h0, phase[i] == PhDone});
    chk({p, ".overflow"}, {31'h0, ao}, {31'h0, ovf[i]});
    chk({p, ".byte_count"}, {24'h0, ac}, 32'(cnt[i] & 8'hff));
  endtask

  initial begin
    for (int i = 0; i < NI; i++) mreset(i);
    forever begin
      @(posedge clk);
      if (rst === 1'b1) for (int i = 0; i < NI; i++) mstep(i);
      @(negedge clk);
      if (rst !== 1'b1) for (int i = 0; i < NI; i++) mreset(i);
      for (int i = 0; i < NI; i++) compare(i);
    end
  end

  task automatic tick(input bit st, input bit rdy, input bit sb, input logic [7:0] b,
                      input bit r);
    start = st; ready = rdy; strobe = sb; byt = b; rd = r;
    @(posedge clk);
    #2;
  endtask

  function automatic bit chance(int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic rand_run();
    tick(1'b1, 1'b0, 1'b0, 8'h00, chance(40));
    repeat ($urandom_range(0, 2))
      tick(chance(10), 1'b0, chance(50), 8'($urandom), chance(40));
    tick(1'b0, 1'b1, chance(50), 8'($urandom), chance(40));
    repeat (40)
      tick(chance(5), chance(20), chance(70), 8'($urandom), chance(40));
    repeat (4) tick(chance(20), 1'b0, 1'b0, 8'h00, chance(50));
  endtask

  initial begin
    start = 1'b0; ready = 1'b0; strobe = 1'b0; rd = 1'b0; byt = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    chk("reset.word", b64.wordxSO, 32'h0);
    chk("reset.valid", {31'h0, b64.word_validxSO}, 32'h0);
    chk("reset.done", {31'h0, b64.donexSO}, 32'h0);
    rst = 1'b1;

    // Full Y=64 run with strobe in ARMED and reg_out timing; Y=40 runs alongside.
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
    chk("armed.reg_out", {31'h0, b64.reg_outxSO}, 32'h0);
    chk("armed.strobe_ignored", {24'h0, b64.byte_countxSO}, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("req.reg_out64", {31'h0, b64.reg_outxSO}, 32'h1);
    chk("req.reg_out40", {31'h0, b40.reg_outxSO}, 32'h1);
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("collect.reg_out", {31'h0, b64.reg_outxSO}, 32'h0);
    for (int k = 0; k < 24; k++) tick(1'b0, 1'b0, 1'b1, 8'(k), 1'b0);
    chk("t1.done_lat1", {31'h0, b64.donexSO}, 32'h0);
    chk("t1.byte_count", {24'h0, b64.byte_countxSO}, 32'd24);
    chk("t2.byte_count", {24'h0, b40.byte_countxSO}, 32'd21);
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t1.done_lat2", {31'h0, b64.donexSO}, 32'h1);
    chk("t3.overflow", {31'h0, b64.overflowxSO}, 32'h1);
    chk("t1.head", b64.wordxSO, 32'h00010203);
    chk("t2.overflow", {31'h0, b40.overflowxSO}, 32'h0);
    for (int p = 0; p < 5; p++) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      if (p == 2) chk("t3.word4", b64.wordxSO, 32'h0c0d0e0f);
    end
    chk("t2.last_word", b40.wordxSO, 32'h14000000);
    chk("t6.pop_empty.valid", {31'h0, b64.word_validxSO}, 32'h0);
    chk("t6.pop_empty.word", b64.wordxSO, 32'h0);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Word-completing strobe and pop together while the depth-4 FIFO is full.
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 24; k++) begin
      tick(1'b0, 1'b0, 1'b1, 8'(8'h20 + k), k == 19);
      if (k == 19) begin
        chk("t4.overflow", {31'h0, b64.overflowxSO}, 32'h0);
        chk("t4.head", b64.wordxSO, 32'h24252627);
      end
    end
    chk("t4.later_overflow", {31'h0, b64.overflowxSO}, 32'h1);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Reset mid-run, then a clean run.
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0);
    rst = 1'b0;
    #1;
    chk("t5.byte_count", {24'h0, b64.byte_countxSO}, 32'h0);
    chk("t5.valid", {31'h0, b64.word_validxSO}, 32'h0);
    chk("t5.word", b64.wordxSO, 32'h0);
    chk("t5.done", {31'h0, b64.donexSO}, 32'h0);
    chk("t5.byte_count40", {24'h0, b40.byte_countxSO}, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 24; k++) tick(1'b0, 1'b0, 1'b1, 8'(8'h40 + k), 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t5.rerun.done", {31'h0, b64.donexSO}, 32'h1);
    chk("t5.rerun.head", b64.wordxSO, 32'h40414243);
    repeat (8) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    for (int r = 0; r < 10; r++) rand_run();
    repeat (12) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
